// File: rtl/cache_pkg.sv
// Shared geometry, line layout and controller state encoding for the
// direct-mapped write-through data cache.
package cache_pkg;

  localparam int unsigned ADDR_BITS      = 32;
  localparam int unsigned WORD_SIZE      = 32;
  localparam int unsigned INDEX_BITS     = 5;
  localparam int unsigned BLOCK_OFFSET   = 6;
  localparam int unsigned WORDS_PER_LINE = 2 ** (BLOCK_OFFSET - 2);
  localparam int unsigned CNT_BITS       = BLOCK_OFFSET - 2;
  localparam int unsigned TAG_BITS       = ADDR_BITS - INDEX_BITS - BLOCK_OFFSET;
  localparam int unsigned DATA_BITS      = WORDS_PER_LINE * WORD_SIZE;
  localparam int unsigned LINE_LENGTH    = TAG_BITS + DATA_BITS + 1;

  // Packed line: {tag, word[N-1] .. word[0], valid}
  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned TAG_LSB   = DATA_BITS + 1;

  function automatic int unsigned word_lsb(input int unsigned k);
    return k * WORD_SIZE + 1;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_WHIT,
    S_FILL,
    S_INSTALL,
    S_WMEM,
    S_RESP
  } state_t;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// CPU, cache-array and memory-bus signals of the fill controller.
// master = controller side, slave = CPU/cache/memory side.
interface cache_fill_ctrl_if;
  import cache_pkg::*;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_BITS-1:0]   cpu_addr;
  logic [WORD_SIZE-1:0]   cpu_wdata;
  logic [WORD_SIZE-1:0]   cpu_rdata;
  logic                   cpu_ready;
  logic                   cpu_busy;

  logic                   cache_enable;
  logic                   cache_re;
  logic                   cache_wr;
  logic                   cache_full_line_wr;
  logic [ADDR_BITS-1:0]   cache_addr;
  logic [WORD_SIZE-1:0]   cache_wdata;
  logic [LINE_LENGTH-1:0] cache_line;
  logic [WORD_SIZE-1:0]   cache_rdata;
  logic                   cache_hit;

  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [WORD_SIZE-1:0]   mem_wdata;
  logic [WORD_SIZE-1:0]   mem_rdata;
  logic                   mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_busy,
    output cache_enable, cache_re, cache_wr, cache_full_line_wr,
    output cache_addr, cache_wdata, cache_line,
    input  cache_rdata, cache_hit,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_busy,
    input  cache_enable, cache_re, cache_wr, cache_full_line_wr,
    input  cache_addr, cache_wdata, cache_line,
    output cache_rdata, cache_hit,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_fill_ctrl_line_buffer.sv
// Fill buffer: one register per line word, written by beat index,
// with a random-access read port and the whole line as a packed vector.
module line_buffer
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [CNT_BITS-1:0]  wr_idx,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [CNT_BITS-1:0]  rd_idx,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [DATA_BITS-1:0] words
);

  logic [WORD_SIZE-1:0] buf_q [WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) buf_q[i] <= '0;
    end else if (we) begin
      buf_q[wr_idx] <= wdata;
    end
  end

  assign rdata = buf_q[rd_idx];

  always_comb begin
    words = '0;
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++)
      words[i*WORD_SIZE +: WORD_SIZE] = buf_q[i];
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache sequencer: tag lookup, 16-beat read-miss line fill with one-cycle
// install, and write-through stores without write-allocate.
module cache_fill_ctrl
  import cache_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cache_fill_ctrl_if.master bus
);

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic [CNT_BITS-1:0]  cnt;
  logic                 en_q;
  logic                 buf_we;
  logic [WORD_SIZE-1:0] buf_rd;
  logic [DATA_BITS-1:0] buf_words;

  line_buffer u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .we     (buf_we),
    .wr_idx (cnt),
    .wdata  (bus.mem_rdata),
    .rd_idx (addr_q[BLOCK_OFFSET-1:2]),
    .rdata  (buf_rd),
    .words  (buf_words)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      en_q    <= 1'b0;
    end else begin
      state <= state_n;
      // Enable is registered so it reads 0 in the cycle right after reset.
      en_q  <= 1'b1;
      case (state)
        S_IDLE: if (bus.cpu_req) begin
          addr_q  <= bus.cpu_addr;
          we_q    <= bus.cpu_we;
          wdata_q <= bus.cpu_wdata;
        end
        S_CHECK: if (!we_q) begin
          if (bus.cache_hit) rdata_q <= bus.cache_rdata;
          else               cnt     <= '0;
        end
        S_FILL:    if (bus.mem_ack) cnt <= cnt + 1'b1;
        S_INSTALL: rdata_q <= buf_rd;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    buf_we  = 1'b0;
    case (state)
      S_IDLE:   if (bus.cpu_req) state_n = S_LOOKUP;
      S_LOOKUP: state_n = S_CHECK;
      S_CHECK: begin
        if (bus.cache_hit) state_n = we_q ? S_WHIT : S_RESP;
        else               state_n = we_q ? S_WMEM : S_FILL;
      end
      S_WHIT: state_n = S_WMEM;
      S_FILL: if (bus.mem_ack) begin
        buf_we = 1'b1;
        if (cnt == CNT_BITS'(WORDS_PER_LINE - 1)) state_n = S_INSTALL;
      end
      S_INSTALL: state_n = S_RESP;
      S_WMEM:    if (bus.mem_ack) state_n = S_RESP;
      S_RESP:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_rdata          = rdata_q;
    bus.cpu_ready          = (state == S_RESP);
    bus.cpu_busy           = (state != S_IDLE);
    bus.cache_enable       = en_q;
    bus.cache_re           = (state == S_LOOKUP);
    bus.cache_wr           = (state == S_WHIT);
    bus.cache_full_line_wr = (state == S_INSTALL);
    bus.cache_addr         = addr_q;
    bus.cache_wdata        = wdata_q;
    bus.cache_line         = '0;
    bus.mem_req            = (state == S_FILL) || (state == S_WMEM);
    bus.mem_we             = (state == S_WMEM);
    bus.mem_addr           = '0;
    bus.mem_wdata          = '0;
    if (state == S_INSTALL) begin
      bus.cache_line[VALID_BIT]                = 1'b1;
      bus.cache_line[word_lsb(0) +: DATA_BITS] = buf_words;
      bus.cache_line[TAG_LSB +: TAG_BITS]      = addr_q[ADDR_BITS-1 -: TAG_BITS];
    end
    if (state == S_FILL)
      bus.mem_addr = {addr_q[ADDR_BITS-1:BLOCK_OFFSET], cnt, 2'b00};
    if (state == S_WMEM) begin
      bus.mem_addr  = {addr_q[ADDR_BITS-1:2], 2'b00};
      bus.mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: behavioural cache array and memory around the
// controller, checked against a per-request reference model.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_ctrl_if bus();

  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return 32'hA0A0_0000 + a;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic        ref_valid [32] = '{default: 1'b0};
  logic [20:0] ref_tag   [32] = '{default: '0};
  logic [31:0] cur_addr = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // ---------------- cache array model ----------------
  logic [31:0]  cd [32][16];
  logic         cv [32] = '{default: 1'b0};
  logic [20:0]  ct [32] = '{default: '0};
  logic         c_re = 1'b0, c_wr = 1'b0, c_fl = 1'b0;
  logic [31:0]  c_addr = '0, c_wdata = '0;
  logic [533:0] c_line = '0;
  int unsigned  n_cwr = 0, n_inst = 0, n_ready = 0;

  always @(negedge clk) begin
    c_re    = bus.cache_re;
    c_wr    = bus.cache_wr;
    c_fl    = bus.cache_full_line_wr;
    c_addr  = bus.cache_addr;
    c_wdata = bus.cache_wdata;
    c_line  = bus.cache_line;
    if (bus.cpu_ready) n_ready++;
    if (c_wr) n_cwr++;
    if (c_fl) begin
      n_inst++;
      check_eq("line_valid", c_line[0], 1'b1);
      check_eq("line_tag", c_line[533:513], cur_addr[31:11]);
      for (int k = 0; k < 16; k++)
        check_eq("line_word", c_line[32*k+1 +: 32],
                 ref_read({cur_addr[31:6], 6'(k*4)}));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bus.cache_hit   <= 1'b0;
      bus.cache_rdata <= '0;
    end else if (c_re) begin
      bus.cache_hit   <= cv[c_addr[10:6]] && (ct[c_addr[10:6]] == c_addr[31:11]);
      bus.cache_rdata <= cd[c_addr[10:6]][c_addr[5:2]];
    end
    if (c_wr && cv[c_addr[10:6]] && ct[c_addr[10:6]] == c_addr[31:11])
      cd[c_addr[10:6]][c_addr[5:2]] <= c_wdata;
    if (c_fl) begin
      cv[c_addr[10:6]] <= 1'b1;
      ct[c_addr[10:6]] <= c_line[533:513];
      for (int k = 0; k < 16; k++) cd[c_addr[10:6]][k] <= c_line[32*k+1 +: 32];
    end
  end

  // ---------------- memory responder ----------------
  logic [31:0] env_mem [logic [31:0]];
  int unsigned wait_cnt = 0, max_delay = 0;
  int unsigned n_rd = 0, n_wr = 0, last_ack_cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] rd_log [$];
  logic [31:0] wr_addr_last = '0, wr_data_last = '0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  end

  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (rst || !bus.mem_req) begin
      pend = 1'b0;
    end else begin
      if (pend) check_eq("mem_addr_stable", bus.mem_addr, pend_addr);
      if (wait_cnt == 0) begin
        bus.mem_ack  = 1'b1;
        last_ack_cyc = cyc;
        if (bus.mem_we) begin
          n_wr++;
          wr_addr_last = bus.mem_addr;
          wr_data_last = bus.mem_wdata;
          env_mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          n_rd++;
          rd_log.push_back(bus.mem_addr);
          bus.mem_rdata = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr]
                                                       : mem_default(bus.mem_addr);
        end
        wait_cnt = $urandom_range(max_delay, 0);
        pend     = 1'b0;
      end else begin
        wait_cnt--;
        pend      = 1'b1;
        pend_addr = bus.mem_addr;
      end
    end
  end

  // ---------------- one CPU request against the reference ----------------
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned idx, t0, rd0, wr0, inst0, cwr0, guard;
    logic        hit, miss_ld;
    logic [31:0] exp_rd;
    idx     = int'(addr[10:6]);
    hit     = ref_valid[idx] && (ref_tag[idx] == addr[31:11]);
    miss_ld = !we && !hit;
    exp_rd  = ref_read(addr);
    rd0 = n_rd; wr0 = n_wr; inst0 = n_inst; cwr0 = n_cwr;
    cur_addr = addr;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    t0 = cyc;
    @(negedge clk);
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;
    check_eq("busy", bus.cpu_busy, 1'b1);
    guard = 0;
    while (!bus.cpu_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_seen", bus.cpu_ready, 1'b1);
    if (!we) check_eq("rdata", bus.cpu_rdata, exp_rd);
    if (!we && hit) check_eq("hit_latency", cyc - t0, 3);
    if (miss_ld) check_eq("fill_ready_latency", cyc - last_ack_cyc, 2);
    @(negedge clk);
    check_eq("ready_pulse", bus.cpu_ready, 1'b0);
    check_eq("idle_busy", bus.cpu_busy, 1'b0);
    if (!we) check_eq("rdata_held", bus.cpu_rdata, exp_rd);
    check_eq("n_mem_rd", n_rd - rd0, miss_ld ? 16 : 0);
    check_eq("n_mem_wr", n_wr - wr0, we ? 1 : 0);
    check_eq("n_install", n_inst - inst0, miss_ld ? 1 : 0);
    check_eq("n_cache_wr", n_cwr - cwr0, (we && hit) ? 1 : 0);
    if (we) begin
      check_eq("wr_addr", wr_addr_last, {addr[31:2], 2'b00});
      check_eq("wr_data", wr_data_last, wdata);
      ref_mem[addr] = wdata;
    end
    if (miss_ld && n_rd - rd0 == 16) begin
      for (int k = 0; k < 16; k++)
        check_eq("fill_addr", rd_log[rd0 + k], {addr[31:6], 6'(k*4)});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr[31:11];
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned rd0, inst0, rdy0, guard;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", bus.cpu_ready, 1'b0);
    check_eq("rst_busy", bus.cpu_busy, 1'b0);
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_enable", bus.cache_enable, 1'b0);
    check_eq("rst_rdata", bus.cpu_rdata, 32'h0);
    check_eq("rst_line_wr", bus.cache_full_line_wr, 1'b0);
    check_eq("rst_line_zero", bus.cache_line == '0, 1'b1);
    check_eq("rst_cache_addr", bus.cache_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_enable", bus.cache_enable, 1'b1);

    max_delay = 0;
    do_op(1'b0, 32'h0000_0100, '0);
    do_op(1'b0, 32'h0000_0108, '0);
    do_op(1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
    do_op(1'b0, 32'h0000_0104, '0);
    do_op(1'b1, 32'h0000_8000, 32'h1234_5678);
    do_op(1'b0, 32'h0000_8000, '0);
    do_op(1'b0, 32'h0000_8000, '0);

    max_delay = 3;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(3, 0) << 11) | ($urandom_range(7, 0) << 6) | ($urandom_range(15, 0) << 2);
      do_op($urandom_range(2, 0) == 0, a, $urandom);
    end

    // Reset in the middle of a fill, then refetch the same line.
    max_delay = 1;
    a = 32'h0004_0200;
    cur_addr = a;
    rd0 = n_rd; inst0 = n_inst; rdy0 = n_ready;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    guard = 0;
    while (n_rd < rd0 + 7 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst_fill_7acks", n_rd >= rd0 + 7, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", bus.cpu_busy, 1'b0);
    check_eq("midrst_mem_req", bus.mem_req, 1'b0);
    check_eq("midrst_line_wr", bus.cache_full_line_wr, 1'b0);
    check_eq("midrst_ready", bus.cpu_ready, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_no_install", n_inst - inst0, 0);
    check_eq("midrst_no_ready", n_ready - rdy0, 0);
    do_op(1'b0, a, '0);
    do_op(1'b0, a + 32'h3C, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
